risc_core_mc: RTL
=================

RISC_CORE_MC -- requirements
Module: risc_core_mc

Interface
REQ-001 Parameter DATA_W, default 8, datapath, register and immediate width (min 4).
REQ-002 Parameter REG_N, default 8, register count, power of two, 2..16; RSEL_W = clog2(REG_N).
REQ-003 Parameter ADDR_W, default 8, program-counter and instruction-address width.
REQ-004 Derived width INSTR_W = 4 + 3*RSEL_W + DATA_W; field order MSB..LSB is opcode[3:0], rd, rs, rt, imm.
REQ-005 Clk100MHz  in  1  single clock; all state changes on its rising edge.
REQ-006 Clr  in  1  reset, synchronous, active-high.
REQ-007 Cen  in  1  step enable; FSM and state registers advance only when 1.
REQ-008 InstrReq  out  1  instruction fetch request.
REQ-009 InstrAddr  out  ADDR_W  fetch address (equals PC).
REQ-010 InstrAck  in  1  fetch data valid this cycle.
REQ-011 InstrData  in  INSTR_W  fetched instruction word.
REQ-012 Switches  in  DATA_W  input port read by IN.
REQ-013 Resume  in  1  leave HALT.
REQ-014 SegData  out  DATA_W  display register.
REQ-015 LEDs  out  DATA_W  LED register.
REQ-016 Halted  out  1  high while in HALT.
REQ-017 PCOut  out  ADDR_W  current PC, for debug.

Function
REQ-018 FSM states FETCH, EXEC, HALT; advancement gated by Cen except Clr.
REQ-019 FETCH: InstrReq=1, InstrAddr=PC; InstrReq held while waiting, independent of Cen.
REQ-020 FETCH->EXEC when InstrAck=1 and Cen=1; InstrData latched into IR that edge.
REQ-021 InstrAck when Cen=0 or outside FETCH is ignored; InstrReq=0 in EXEC and HALT.
REQ-022 EXEC lasts exactly one enabled cycle: writeback, output-register writes and PC update on that edge, then FETCH (HALT for opcode F).
REQ-023 Opcodes: 0 NOP; 1 LI rd=imm; 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR; 7 SLT rd=(rs<rt unsigned)?1:0.
REQ-024 Opcodes: 8 BEQ; 9 JI PC=imm; A JR PC=rs; B IN rd=Switches; C OUT7 SegData=rs; D OUTLED LEDs=rs; E JAL rd=PC+1, PC=imm; F HALT.
REQ-025 ALU results are modulo 2^DATA_W; carry and borrow discarded.
REQ-026 BEQ: if rs==rt then PC=PC+imm (imm two's-complement, sign-extended/truncated to ADDR_W), else PC=PC+1.
REQ-027 All other non-jump opcodes: PC=PC+1; PC wraps from 2^ADDR_W-1 to 0.
REQ-028 Jump targets from DATA_W values are zero-extended or truncated to ADDR_W.
REQ-029 R0 reads 0; writes to R0 discarded.
REQ-030 Register reads in EXEC see pre-edge values (rd==rs reads the old value).
REQ-031 HALT: PC stays at HALT address+1; Halted=1; Resume=1 with Cen=1 -> FETCH.
REQ-032 Clr overrides Cen, InstrAck and Resume in the same cycle.

Reset
REQ-033 On Clr: state=FETCH, PC=0, IR=0, all registers=0, SegData=0, LEDs=0, Halted=0.
REQ-034 InstrReq is 1 in the first cycle after Clr deasserts; a fetch pending during Clr is abandoned and any coincident InstrAck is dropped.

Structure
REQ-035 Shared package risc_pkg holds the opcode enumeration, the FSM state typedef, and opcode/field-width constants.
REQ-036 One sub-module, risc_regfile (REG_N x DATA_W, two asynchronous reads, one synchronous write, R0 zero); ALU and FSM are inline.

Verification
REQ-037 Defaults, program LI R1,5; LI R2,3; ADD R3,R1,R2; OUT7 R3; HALT with zero-wait ack -> SegData=8, Halted=1, PCOut=5.
REQ-038 InstrAck delayed 3 cycles per fetch -> InstrReq and InstrAddr held stable 3 cycles; results identical to REQ-037.
REQ-039 LI R1,7; LI R2,7; BEQ R1,R2,-2 -> PC sequence 0,1,2,0; with R2=6 -> PC goes to 3.
REQ-040 LI R1,200; LI R2,100; ADD R3,R1,R2; OUTLED R3 -> LEDs=44; SUB R3,R2,R1 -> 156; LI R0,9; OUTLED R0 -> LEDs=0.
REQ-041 Cen low 10 cycles mid-EXEC, then Clr pulsed mid-FETCH -> no state change while Cen low; after Clr all outputs 0, fetch restarts at address 0.
REQ-042 DATA_W=16, REG_N=16, ADDR_W=10: JAL R15,1023; at 1023 JR R15 -> R15=1, PC returns to 1; NOP at 1023 -> PC wraps to 0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_core_mc shared types.
// Opcodes, FSM states and field widths.
package risc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LI     = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_SLT    = 4'h7,
    OP_BEQ    = 4'h8,
    OP_JI     = 4'h9,
    OP_JR     = 4'hA,
    OP_IN     = 4'hB,
    OP_OUT7   = 4'hC,
    OP_OUTLED = 4'hD,
    OP_JAL    = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic int instr_width(input int data_w, input int rsel_w);
    return OP_W + 3 * rsel_w + data_w;
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// Register file: two async reads, one sync write.
// R0 always reads zero; writes to it are dropped.
module risc_regfile
  import risc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int RSEL_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [RSEL_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RSEL_W-1:0] addr_a,
  input  logic [RSEL_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  logic [DATA_W-1:0] regs [REG_N];

  // clear all on reset, otherwise single write port
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign data_a = (addr_a == '0) ? '0 : regs[addr_a];
  assign data_b = (addr_b == '0) ? '0 : regs[addr_b];

endmodule

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core: FETCH / EXEC / HALT.
// Inline ALU and FSM, external register file.
module risc_core_mc
  import risc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_N   = 8,
  parameter  int ADDR_W  = 8,
  localparam int RSEL_W  = $clog2(REG_N),
  localparam int INSTR_W = OP_W + 3 * RSEL_W + DATA_W
) (
  input  logic               Clk100MHz,
  input  logic               Clr,
  input  logic               Cen,
  output logic               InstrReq,
  output logic [ADDR_W-1:0]  InstrAddr,
  input  logic               InstrAck,
  input  logic [INSTR_W-1:0] InstrData,
  input  logic [DATA_W-1:0]  Switches,
  input  logic               Resume,
  output logic [DATA_W-1:0]  SegData,
  output logic [DATA_W-1:0]  LEDs,
  output logic               Halted,
  output logic [ADDR_W-1:0]  PCOut
);

  state_e             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;

  opcode_e            op;
  logic [RSEL_W-1:0]  rd;
  logic [RSEL_W-1:0]  rs;
  logic [RSEL_W-1:0]  rt;
  logic [DATA_W-1:0]  imm;

  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rt_val;
  logic [DATA_W-1:0]  wdata;
  logic               wr_op;
  logic               we;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  boff;
  logic [ADDR_W-1:0]  pc_next;

  assign op  = opcode_e'(ir[INSTR_W-1 -: OP_W]);
  assign rd  = ir[DATA_W+3*RSEL_W-1 -: RSEL_W];
  assign rs  = ir[DATA_W+2*RSEL_W-1 -: RSEL_W];
  assign rt  = ir[DATA_W+RSEL_W-1 -: RSEL_W];
  assign imm = ir[DATA_W-1:0];

  assign pc_inc = pc + ADDR_W'(1);
  assign boff   = ADDR_W'(signed'(imm));

  assign we = Cen && (state == ST_EXEC) && wr_op;

  risc_regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N),
    .RSEL_W(RSEL_W)
  ) u_rf (
    .clk    (Clk100MHz),
    .clr    (Clr),
    .we     (we),
    .wr_addr(rd),
    .wr_data(wdata),
    .addr_a (rs),
    .addr_b (rt),
    .data_a (rs_val),
    .data_b (rt_val)
  );

  // decode + ALU + next-PC for the instruction held in IR
  always_comb begin
    wr_op   = 1'b0;
    wdata   = '0;
    pc_next = pc_inc;
    unique case (op)
      OP_NOP: ;
      OP_LI: begin
        wr_op = 1'b1;
        wdata = imm;
      end
      OP_ADD: begin
        wr_op = 1'b1;
        wdata = rs_val + rt_val;
      end
      OP_SUB: begin
        wr_op = 1'b1;
        wdata = rs_val - rt_val;
      end
      OP_AND: begin
        wr_op = 1'b1;
        wdata = rs_val & rt_val;
      end
      OP_OR: begin
        wr_op = 1'b1;
        wdata = rs_val | rt_val;
      end
      OP_XOR: begin
        wr_op = 1'b1;
        wdata = rs_val ^ rt_val;
      end
      OP_SLT: begin
        wr_op = 1'b1;
        wdata = DATA_W'(rs_val < rt_val);
      end
      OP_BEQ: begin
        if (rs_val == rt_val) pc_next = pc + boff;
      end
      OP_JI:  pc_next = ADDR_W'(imm);
      OP_JR:  pc_next = ADDR_W'(rs_val);
      OP_IN: begin
        wr_op = 1'b1;
        wdata = Switches;
      end
      OP_OUT7:   ;
      OP_OUTLED: ;
      OP_JAL: begin
        wr_op   = 1'b1;
        wdata   = DATA_W'(pc_inc);
        pc_next = ADDR_W'(imm);
      end
      OP_HALT: ;
      default: ;
    endcase
  end

  // control FSM, PC, IR and output registers
  always_ff @(posedge Clk100MHz) begin
    if (Clr) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      SegData <= '0;
      LEDs    <= '0;
    end else if (Cen) begin
      unique case (state)
        ST_FETCH: begin
          if (InstrAck) begin
            ir    <= InstrData;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc <= pc_next;
          if (op == OP_OUT7)   SegData <= rs_val;
          if (op == OP_OUTLED) LEDs    <= rs_val;
          state <= (op == OP_HALT) ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          if (Resume) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign InstrReq  = (state == ST_FETCH);
  assign InstrAddr = pc;
  assign Halted    = (state == ST_HALT);
  assign PCOut     = pc;

endmodule
